// File: rtl/ram2_ctrl_pkg.sv
// Shared types and constants for the RAM2 asynchronous SRAM controller.
// Chip-control decoding lives here so the FSM and its registered outputs agree.
package ram2_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  localparam int CNT_W = 3;

  localparam logic       RAM_CHIP_ENABLE  = 1'b0;
  localparam logic       RAM_CHIP_DISABLE = 1'b1;
  localparam logic [3:0] RAM_BE_ALL       = 4'h0;
  localparam logic [3:0] RAM_BE_NONE      = 4'hF;
  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

  typedef struct packed {
    logic       ce_n;
    logic       oe_n;
    logic       we_n;
    logic [3:0] be_n;
    logic       drive;
  } chip_ctl_t;

  // Chip pin levels that belong to each state; drive marks the data-bus owner.
  function automatic chip_ctl_t chip_ctl(input state_t st, input logic [3:0] sel);
    chip_ctl_t c;
    c.ce_n  = RAM_CHIP_DISABLE;
    c.oe_n  = RAM_CHIP_DISABLE;
    c.we_n  = RAM_CHIP_DISABLE;
    c.be_n  = RAM_BE_NONE;
    c.drive = 1'b0;
    case (st)
      ST_RD: begin
        c.ce_n = RAM_CHIP_ENABLE;
        c.oe_n = RAM_CHIP_ENABLE;
        c.be_n = RAM_BE_ALL;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        c.ce_n  = RAM_CHIP_ENABLE;
        c.be_n  = ~sel;
        c.drive = 1'b1;
      end
      ST_WR_PULSE: begin
        c.ce_n  = RAM_CHIP_ENABLE;
        c.we_n  = RAM_CHIP_ENABLE;
        c.be_n  = ~sel;
        c.drive = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram2_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline and the RAM2 controller.
interface ram2_ctrl_if;

  logic        mem_ce_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        stall_req_o;

  modport master (
    output mem_ce_i, mem_re_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, stall_req_o
  );

  modport slave (
    input  mem_ce_i, mem_re_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, stall_req_o
  );

endinterface

// File: rtl/ram2_wait_counter.sv
// Loadable 3-bit down-counter timing the OE-low and WE-low phases.
module ram2_wait_counter
  import ram2_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ram2_ctrl.sv
// Multi-cycle access sequencer for the RAM2 asynchronous SRAM: one request at a
// time, registered chip controls, stall while busy and a one-cycle ack.
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram2_ctrl_if.slave        mem,
  output logic [ADDR_W-1:0] ram2_addr_o,
  inout  wire  [31:0]       ram2_data_io,
  output logic              ram2_ce_n,
  output logic              ram2_oe_n,
  output logic              ram2_we_n,
  output logic [3:0]        ram2_be_n
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t      state;
  state_t      next_state;
  logic        req;
  logic        accept;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;
  logic        stall;
  logic        drive;
  logic [3:0]  sel_next;
  chip_ctl_t   ctl_next;
  logic [31:0] wdata_p0;
  logic [3:0]  sel_p0;
  logic        unused_addr_bits;

  assign req    = mem.mem_ce_i && (mem.mem_re_i || mem.mem_we_i);
  assign accept = (state == ST_IDLE) && req;

  // Only the word-address bits reach the chip.
  assign unused_addr_bits = ^{mem.mem_addr_i[31:ADDR_W+2], mem.mem_addr_i[1:0]};

  ram2_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          stall = 1'b1;
          // A store takes priority when both directions are requested.
          if (mem.mem_we_i) begin
            next_state = ST_WR_SETUP;
          end else begin
            next_state = ST_RD;
            cnt_load   = 1'b1;
          end
        end
      end
      ST_RD: begin
        stall   = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) next_state = ST_DONE;
      end
      ST_WR_SETUP: begin
        stall      = 1'b1;
        cnt_load   = 1'b1;
        next_state = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        stall   = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) next_state = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        stall      = 1'b1;
        next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign mem.stall_req_o = stall;

  // Controls are registered from the next state so pins line up with the state.
  assign sel_next = (state == ST_IDLE) ? mem.mem_sel_i : sel_p0;
  assign ctl_next = chip_ctl(next_state, sel_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram2_ce_n      <= RAM_CHIP_DISABLE;
      ram2_oe_n      <= RAM_CHIP_DISABLE;
      ram2_we_n      <= RAM_CHIP_DISABLE;
      ram2_be_n      <= RAM_BE_NONE;
      drive          <= 1'b0;
      mem.mem_ack_o  <= 1'b0;
      ram2_addr_o    <= '0;
      mem.mem_data_o <= ZERO_WORD;
    end else begin
      ram2_ce_n     <= ctl_next.ce_n;
      ram2_oe_n     <= ctl_next.oe_n;
      ram2_we_n     <= ctl_next.we_n;
      ram2_be_n     <= ctl_next.be_n;
      drive         <= ctl_next.drive;
      mem.mem_ack_o <= (next_state == ST_DONE);
      if (accept) begin
        ram2_addr_o <= mem.mem_addr_i[ADDR_W+1:2];
      end
      if ((state == ST_RD) && cnt_zero) begin
        mem.mem_data_o <= ram2_data_io;
      end
    end
  end

  // Request payload latch; held for the whole access regardless of input changes.
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_p0 <= mem.mem_data_i;
      sel_p0   <= mem.mem_sel_i;
    end
  end

  assign ram2_data_io = drive ? wdata_p0 : 32'bz;

endmodule
